// File: rtl/lieat_axi_rd_arbiter_pkg.sv
// rtl/lieat_axi_rd_arbiter_pkg.sv - shared widths and FSM encoding for the DRAM read-channel arbiter
package lieat_axi_rd_arbiter_pkg;

  localparam int XLEN = 32;
  localparam int LENW_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } rd_state_e;

endpackage

// File: rtl/lieat_rr_arb2.sv
// rtl/lieat_rr_arb2.sv - two-way round-robin grant with last-grant memory
module lieat_rr_arb2 (
  input  logic       clk,
  input  logic       rstn,
  input  logic [1:0] req_i,
  input  logic       upd_en_i,
  input  logic       upd_id_i,
  output logic [1:0] gnt_o,
  output logic       gnt_id_o
);

  logic rr_last_q;
  logic rr_last_d;

  // Reset value 1 lets port 0 win the very first contested round.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rr_last_q <= 1'b1;
    end else begin
      rr_last_q <= rr_last_d;
    end
  end

  always_comb begin
    rr_last_d = rr_last_q;
    if (upd_en_i) begin
      rr_last_d = upd_id_i;
    end
  end

  always_comb begin
    gnt_id_o = req_i[1] & (~req_i[0] | ~rr_last_q);
    gnt_o    = {req_i[1] & gnt_id_o, req_i[0] & ~gnt_id_o};
  end

endmodule

// File: rtl/lieat_axi_rd_arbiter.sv
// rtl/lieat_axi_rd_arbiter.sv - shares one AXI read channel between icache (port 0) and dcache (port 1)
module lieat_axi_rd_arbiter
  import lieat_axi_rd_arbiter_pkg::*;
#(
  parameter int AW   = XLEN,
  parameter int DW   = XLEN,
  parameter int LENW = LENW_DEF
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            s0_arvalid,
  output logic            s0_arready,
  input  logic [AW-1:0]   s0_araddr,
  input  logic [LENW-1:0] s0_arlen,
  output logic            s0_rvalid,
  input  logic            s0_rready,
  output logic [DW-1:0]   s0_rdata,
  output logic            s0_rlast,
  input  logic            s1_arvalid,
  output logic            s1_arready,
  input  logic [AW-1:0]   s1_araddr,
  input  logic [LENW-1:0] s1_arlen,
  output logic            s1_rvalid,
  input  logic            s1_rready,
  output logic [DW-1:0]   s1_rdata,
  output logic            s1_rlast,
  output logic            m_arvalid,
  input  logic            m_arready,
  output logic [AW-1:0]   m_araddr,
  output logic [LENW-1:0] m_arlen,
  input  logic            m_rvalid,
  output logic            m_rready,
  input  logic [DW-1:0]   m_rdata,
  input  logic            m_rlast,
  output logic            busy,
  output logic            len_err
);

  rd_state_e       state_q, state_d;
  logic            owner_q, owner_d;
  logic [AW-1:0]   araddr_q, araddr_d;
  logic [LENW-1:0] arlen_q, arlen_d;
  logic [LENW-1:0] beat_cnt_q, beat_cnt_d;
  logic            len_err_q, len_err_d;

  logic [1:0] req;
  logic [1:0] gnt;
  logic       gnt_id;
  logic       upd_en;
  logic       in_idle;
  logic       in_data;
  logic       r_hs;

  assign req     = {s1_arvalid, s0_arvalid};
  assign in_idle = (state_q == ST_IDLE);
  assign in_data = (state_q == ST_DATA);

  lieat_rr_arb2 u_rr_arb2 (
    .clk      (clk),
    .rstn     (rstn),
    .req_i    (req),
    .upd_en_i (upd_en),
    .upd_id_i (owner_q),
    .gnt_o    (gnt),
    .gnt_id_o (gnt_id)
  );

  assign s0_arready = in_idle & gnt[0];
  assign s1_arready = in_idle & gnt[1];

  assign m_arvalid = (state_q == ST_ADDR);
  assign m_araddr  = araddr_q;
  assign m_arlen   = arlen_q;
  assign busy      = ~in_idle;
  assign len_err   = len_err_q;

  // R channel is only connected to the owner while a burst is in flight.
  assign m_rready  = in_data & (owner_q ? s1_rready : s0_rready);
  assign r_hs      = m_rvalid & m_rready;

  assign s0_rvalid = in_data & ~owner_q & m_rvalid;
  assign s0_rlast  = in_data & ~owner_q & m_rlast;
  assign s0_rdata  = (in_data & ~owner_q) ? m_rdata : '0;
  assign s1_rvalid = in_data & owner_q & m_rvalid;
  assign s1_rlast  = in_data & owner_q & m_rlast;
  assign s1_rdata  = (in_data & owner_q) ? m_rdata : '0;

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    araddr_d   = araddr_q;
    arlen_d    = arlen_q;
    beat_cnt_d = beat_cnt_q;
    len_err_d  = len_err_q;
    upd_en     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          owner_d    = gnt_id;
          araddr_d   = gnt_id ? s1_araddr : s0_araddr;
          arlen_d    = gnt_id ? s1_arlen : s0_arlen;
          beat_cnt_d = '0;
          state_d    = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (m_arready) begin
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (r_hs) begin
          // Counter freezes at arlen so an overrunning slave cannot wrap it.
          if (beat_cnt_q != arlen_q) begin
            beat_cnt_d = beat_cnt_q + LENW'(1);
          end
          if (m_rlast) begin
            state_d = ST_IDLE;
            upd_en  = 1'b1;
            if (beat_cnt_q != arlen_q) begin
              len_err_d = 1'b1;
            end
          end else if (beat_cnt_q == arlen_q) begin
            len_err_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      owner_q    <= 1'b0;
      araddr_q   <= '0;
      arlen_q    <= '0;
      beat_cnt_q <= '0;
      len_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      araddr_q   <= araddr_d;
      arlen_q    <= arlen_d;
      beat_cnt_q <= beat_cnt_d;
      len_err_q  <= len_err_d;
    end
  end

endmodule
